// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit.
// The FAULT state exists only when FETCH_MISALIGN_TRAP_EN is defined.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE, RUN, FAULT} fetch_state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} fetch_state_t;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small fetch FIFO of {pc, instr} entries with flush; the head is visible combinationally.
// Push while full is accepted only when a pop frees a slot in the same cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_instr,
  input  logic                     pop,
  output logic                     accepted,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              head_pc,
  output logic [31:0]              head_instr
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_reg [DEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW:0]   count_reg;
  logic          do_pop;
  logic          do_push;

  assign do_pop   = pop && (count_reg != '0);
  assign do_push  = push && ((count_reg != (PW+1)'(DEPTH)) || do_pop);
  assign accepted = do_push && !flush;

  assign count      = count_reg;
  assign head_pc    = mem_reg[rd_ptr_reg].pc;
  assign head_instr = mem_reg[rd_ptr_reg].instr;

  // Entries are cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= '{pc: push_pc, instr: push_instr};
        wr_ptr_reg          <= wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_reg + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: pc register, IDLE/RUN FSM and a fetch buffer toward decode.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects in a FAULT state.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        if_fault
);

  fetch_state_t               state_reg;
  logic [31:0]                pc_reg;
  logic [31:0]                target;
  logic                       fetching;
  logic                       pushed;
  logic [$clog2(BUF_DEPTH):0] count;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_reg;
  logic misaligned;
  assign target     = redirect_pc;
  assign misaligned = redirect_pc[1:0] != 2'b00;
  assign if_fault   = fault_reg;
`else
  assign target   = {redirect_pc[31:2], 2'b00};
  assign if_fault = 1'b0;
`endif

  assign imem_addr = pc_reg;
  assign fetching  = (state_reg == RUN) && !redirect_valid;
  assign if_valid  = count != '0;

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (fetching),
    .push_pc    (pc_reg),
    .push_instr (imem_instr),
    .pop        (id_ready),
    .accepted   (pushed),
    .count      (count),
    .head_pc    (if_pc),
    .head_instr (if_instr)
  );

  // A redirect wins over everything else, in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_reg <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc_reg <= target;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misaligned) begin
        state_reg <= FAULT;
        fault_reg <= 1'b1;
      end else begin
        state_reg <= fetch_en ? RUN : IDLE;
        fault_reg <= 1'b0;
      end
`else
      state_reg <= fetch_en ? RUN : IDLE;
`endif
    end else begin
      if (pushed) begin
        pc_reg <= pc_reg + 32'd4;
      end
      case (state_reg)
        IDLE:    if (fetch_en) state_reg <= RUN;
        RUN:     if (!fetch_en) state_reg <= IDLE;
        default: state_reg <= state_reg;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: fetch-buffer entries, power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port fetch_en  input  1  permits fetching when high.
REQ-006 SHALL have port imem_addr  output  32  byte address to instruction memory.
REQ-007 SHALL have port imem_instr  input  32  word returned combinationally for imem_addr in the same cycle.
REQ-008 SHALL have port redirect_valid  input  1  branch or jump redirect request.
REQ-009 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-010 SHALL have port if_valid  output  1  buffer head holds a valid instruction.
REQ-011 SHALL have port if_instr  output  32  head instruction.
REQ-012 SHALL have port if_pc  output  32  head instruction byte address.
REQ-013 SHALL have port id_ready  input  1  decode accepts the head this cycle.
REQ-014 SHALL have port if_fault  output  1  misaligned-redirect fault flag.

Function
REQ-015 SHALL drive imem_addr directly from the internal pc register, with no combinational path from any input.
REQ-016 SHALL implement FSM states IDLE, RUN and FAULT: IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0; FAULT per REQ-027.
REQ-017 SHALL, in RUN with no redirect, push {pc, imem_instr} and set pc<=pc+4 when count<BUF_DEPTH or a pop occurs the same cycle; otherwise hold pc.
REQ-018 SHALL pop on if_valid & id_ready; if_valid=(count!=0); if_instr and if_pc always reflect the head entry.
REQ-019 SHALL support simultaneous push and pop when the buffer is full, leaving count unchanged.
REQ-020 SHALL wrap pc modulo 2^32 (32'hFFFF_FFFC+4 -> 32'h0000_0000).
REQ-021 SHALL, on redirect_valid=1, flush all entries (count<=0), load pc<=redirect_pc and suppress that cycle's push; any coincident pop is absorbed by the flush.
REQ-022 SHALL honour redirect in every state, including IDLE, where pc is loaded but no fetch occurs.
REQ-023 SHALL have latency: redirect sampled at edge E0 -> target fetched during E0..E1 -> if_valid=1 with if_pc=target after E1.
REQ-024 SHALL hold pc and buffer contents unchanged while in IDLE; pops still drain the buffer.

Reset
REQ-025 SHALL, while rst_n=0, force pc=RESET_PC, count=0, state=IDLE, if_valid=0, if_instr=0, if_pc=0 and if_fault=0 asynchronously; reset mid-operation discards all entries.

Configuration
REQ-026 SHALL, with FETCH_MISALIGN_TRAP_EN defined, enter FAULT on a redirect with redirect_pc[1:0]!=0: flush, pc<=redirect_pc, if_fault=1, no fetches.
REQ-027 SHALL, with FETCH_MISALIGN_TRAP_EN defined, leave FAULT only on reset or an aligned redirect, which clears if_fault and goes to RUN or IDLE according to fetch_en.
REQ-028 SHALL, without FETCH_MISALIGN_TRAP_EN, force redirect_pc[1:0] to 2'b00, tie if_fault to 0 and omit the FAULT state.

Structure
REQ-029 SHALL place the state enum, the fetch-entry struct {pc[31:0], instr[31:0]} and the RESET_PC default in shared package fetch_pkg.
REQ-030 SHALL implement the buffer as sub-module fetch_buffer: a BUF_DEPTH FIFO with flush, push, pop, count and head outputs.

Verification
Bench memory model: word i = 32'hA000_0000+i.
REQ-031 SHALL verify reset: fetch_en=1, id_ready=1 after reset -> if_pc sequence 0,4,8,... with if_instr A0000000, A0000001, A0000002, one per cycle.
REQ-032 SHALL verify backpressure: id_ready=0 for 5 cycles -> count saturates at 2, pc holds at 8, if_pc stays 0; on release, no instruction is skipped or duplicated.
REQ-033 SHALL verify redirect: redirect to 32'h40 while full with id_ready=1 -> both entries discarded; after 2 edges if_pc=40, if_instr=A0000010.
REQ-034 SHALL verify wrap: RESET_PC=32'hFFFF_FFF8 -> if_pc FFFFFFF8, FFFFFFFC, 00000000.
REQ-035 SHALL verify misalignment: redirect to 32'h42 -> with the macro, if_fault=1 and no pushes until redirect to 32'h80 clears it; without the macro, next if_pc=40.
REQ-036 SHALL verify async reset: rst_n asserted mid-stream between edges -> outputs zero immediately; after release, fetching restarts at RESET_PC.
